// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard front end: synchronises the raw pins, captures and checks
// 11-bit frames, buffers good bytes in a small FIFO and folds E0/F0 prefixes
// into single decoded key events for the downstream lookup stage.
//
// Handshake: key_valid/key_ready follow strict valid/ready rules. An event
// transfers on any cycle where key_valid && key_ready. Once key_valid is
// raised, key_code/key_break/key_ext stay stable until that transfer, and
// key_valid never drops without a transfer.
`timescale 1ns/1ps
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic [7:0] make_count,
  output logic       frame_err,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } dec_state_t;

  // ---------------------------------------------------------------------
  // Pin synchronisers; flops reset to 1 to match an idle (high) bus.
  // ---------------------------------------------------------------------
  logic ck_s1, ck_s2, ck_hist;
  logic dt_s1, dt_s2;
  logic ps2_fall;

  // Two-flop synchronisers plus one clock-history flop for edge detection.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ck_s1   <= 1'b1;
      ck_s2   <= 1'b1;
      ck_hist <= 1'b1;
      dt_s1   <= 1'b1;
      dt_s2   <= 1'b1;
    end else begin
      ck_s1   <= ps2_clk;
      ck_s2   <= ck_s1;
      ck_hist <= ck_s2;
      dt_s1   <= ps2_data;
      dt_s2   <= dt_s1;
    end
  end

  assign ps2_fall = ck_hist & ~ck_s2;

  // ---------------------------------------------------------------------
  // Frame capture. Bits shift in from the top, so after ten edges
  // frame[0] is the start bit and frame[9] is parity; the stop bit is
  // taken straight from the synchroniser on the eleventh edge.
  // ---------------------------------------------------------------------
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [10:0]   frame_full;
  logic          frame_good;
  logic          push_req;
  logic [7:0]    push_byte;

  // Start low, stop high, odd parity over data plus parity bit.
  always_comb begin
    frame_full = {dt_s2, frame};
    frame_good = ~frame_full[0] & frame_full[10] & (^frame_full[9:1]);
  end

  // Bit counter, shift register, idle timeout and frame check.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      frame     <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
      push_req  <= 1'b0;
      push_byte <= '0;
    end else begin
      frame_err <= 1'b0;
      push_req  <= 1'b0;
      if (ps2_fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_good) begin
            push_req  <= 1'b1;
            push_byte <= frame_full[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          frame   <= {dt_s2, frame[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled partial frame is silently abandoned.
        if (to_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
          to_cnt  <= '0;
          bit_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Raw-byte FIFO. A pop in the same cycle frees a slot, so a push into a
  // full FIFO is still accepted when the decoder pops alongside it.
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full;
  logic          pop, push_ok;
  logic [7:0]    pop_byte;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = ~fifo_empty & (~key_valid | key_ready);
  assign push_ok    = push_req & (~fifo_full | pop);
  assign pop_byte   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_byte;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------
  dec_state_t state, state_nxt;
  logic       emit, emit_brk, emit_ext;
  logic       is_e0, is_f0;

  assign is_e0     = (pop_byte == 8'hE0);
  assign is_f0     = (pop_byte == 8'hF0);
  assign dbg_state = state;

  // Decoder state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and event emission for the byte popped this cycle.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_brk  = 1'b0;
    emit_ext  = 1'b0;
    if (pop) begin
      case (state)
        S_IDLE: begin
          if (is_e0)      state_nxt = S_EXT;
          else if (is_f0) state_nxt = S_BRK;
          else            emit      = 1'b1;
        end
        S_EXT: begin
          if (is_f0)      state_nxt = S_EXT_BRK;
          else if (is_e0) state_nxt = S_EXT;
          else begin
            emit      = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (is_f0)      state_nxt = S_BRK;
          else if (is_e0) state_nxt = S_EXT_BRK;
          else begin
            emit      = 1'b1;
            emit_brk  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: begin
          if (is_e0 || is_f0) state_nxt = S_EXT_BRK;
          else begin
            emit      = 1'b1;
            emit_brk  = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  // Output event register: load on emit, clear valid after a transfer.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_break <= 1'b0;
      key_ext   <= 1'b0;
    end else if (emit) begin
      key_valid <= 1'b1;
      key_code  <= pop_byte;
      key_break <= emit_brk;
      key_ext   <= emit_ext;
    end else if (key_ready) begin
      key_valid <= 1'b0;
    end
  end

  // Count make events as they are handed off.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                                 make_count <= '0;
    else if (key_valid && key_ready && !key_break) make_count <= make_count + 8'd1;
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: drives PS/2 frames on the raw pins and
// checks decoded events against a byte-level prefix model.
`timescale 1ns/1ps
module tb_ps2_scan_decoder;

  localparam int TO = 300;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk, ps2_data;
  logic       key_valid, key_ready;
  logic [7:0] key_code;
  logic       key_break, key_ext;
  logic [7:0] make_count;
  logic       frame_err, overflow;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_break(key_break), .key_ext(key_ext), .make_count(make_count),
    .frame_err(frame_err), .overflow(overflow), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         tests = 0;
  int         fails = 0;
  logic [9:0] exp_q[$];        // {break, ext, code}
  int         exp_make = 0;
  int         err_seen = 0;
  bit         model_ext = 0, model_brk = 0;
  bit         hold_v = 0;
  logic [9:0] hold_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-level prefix model: prefixes set flags, anything else is an event.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0)      model_ext = 1;
    else if (b == 8'hF0) model_brk = 1;
    else begin
      exp_q.push_back({model_brk, model_ext, b});
      model_ext = 0;
      model_brk = 0;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    make_frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!clrn) begin
      exp_make = 0;
      hold_v   = 0;
    end else begin
      check("make_count", make_count, exp_make);
      if (frame_err) err_seen++;
      if (hold_v && key_valid) check("hold_stable", {key_break, key_ext, key_code}, hold_val);
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_event actual=%0h required=none", {key_break, key_ext, key_code});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("event", {key_break, key_ext, key_code}, e);
          if (!e[9]) exp_make++;
        end
        hold_v = 0;
      end else if (key_valid) begin
        hold_v   = 1;
        hold_val = {key_break, key_ext, key_code};
      end else begin
        hold_v = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(4);
      ps2_clk = 1'b0;
      tick(8);
      ps2_clk = 1'b1;
      tick(4);
    end
    ps2_data = 1'b1;
    tick(8);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit dropped);
    if (!bad_par && !bad_stop && !dropped) model_byte(b);
    send_bits(make_frame(b, bad_par, bad_stop), 11);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    exp_q.delete();
    model_ext = 0;
    model_brk = 0;
    tick(3);
    clrn = 1'b1;
    tick(2);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || key_valid) && n < 500) begin
      tick(1);
      n++;
    end
    check({name, "_drain_timeout"}, (n >= 500), 0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!key_valid && n < 500) begin
      tick(1);
      n++;
    end
    check({name, "_valid_timeout"}, (n >= 500), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600us;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    clrn      = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    key_ready = 1'b1;
    tick(3);
    check("rst_key_valid",  key_valid,  0);
    check("rst_key_code",   key_code,   0);
    check("rst_make_count", make_count, 0);
    check("rst_frame_err",  frame_err,  0);
    check("rst_overflow",   overflow,   0);
    check("rst_state",      dbg_state,  0);
    clrn = 1'b1;
    tick(2);

    // Pin the frame builder: 0x1C has three ones, so parity is 0.
    check("frame_1c", make_frame(8'h1C, 0, 0), 11'h438);

    // Single make code.
    send_byte(8'h1C, 0, 0, 0);
    wait_drain("make_1c");
    check("t1_make_count", make_count, 1);
    check("t1_key_code",   key_code,   8'h1C);

    // Break of 1C.
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h1C, 0, 0, 0);
    wait_drain("break_1c");
    check("t2_key_code",   key_code,   8'h1C);
    check("t2_key_break",  key_break,  1);
    check("t2_key_ext",    key_ext,    0);
    check("t2_make_count", make_count, 1);

    // Extended break held by backpressure.
    key_ready = 1'b0;
    send_byte(8'hE0, 0, 0, 0);
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h75, 0, 0, 0);
    wait_valid("ext_brk");
    check("t3_event_early", {key_break, key_ext, key_code}, 10'h375);
    tick(20);
    check("t3_valid_held", key_valid, 1);
    check("t3_event_late", {key_break, key_ext, key_code}, 10'h375);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    tick(1);
    check("t3_valid_dropped", key_valid, 0);
    key_ready = 1'b1;
    wait_drain("ext_brk");
    check("t3_make_count", make_count, 1);

    // Bad parity then bad stop.
    err_seen = 0;
    send_byte(8'h1C, 1, 0, 0);
    send_byte(8'h1B, 0, 1, 0);
    tick(5);
    check("t4_frame_errs", err_seen,  2);
    check("t4_no_valid",   key_valid, 0);

    // Overflow: output register plus 8 FIFO entries, tenth byte dropped.
    do_reset();
    check("t5_ovf_clear", overflow,   0);
    check("t5_count_rst", make_count, 0);
    key_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'h15 + 8'(i), 0, 0, (i == 9));
    check("t5_overflow",  overflow,  1);
    check("t5_head",      key_code,  8'h15);
    check("t5_head_vld",  key_valid, 1);
    key_ready = 1'b1;
    wait_drain("overflow");
    check("t5_make_count", make_count, 9);
    check("t5_ovf_sticky", overflow,   1);

    // Timeout discards a partial frame without an error.
    err_seen = 0;
    send_bits(make_frame(8'h2A, 0, 0), 5);
    tick(TO + 10);
    send_byte(8'h1C, 0, 0, 0);
    wait_drain("timeout");
    check("t6_no_frame_err", err_seen,   0);
    check("t6_make_count",   make_count, 10);
    check("t6_key_code",     key_code,   8'h1C);

    // Reset mid-prefix and mid-frame: next frame decodes as a plain make.
    send_byte(8'hF0, 0, 0, 0);
    send_bits(make_frame(8'h33, 0, 0), 4);
    do_reset();
    send_byte(8'h1C, 0, 0, 0);
    wait_drain("reset_mid");
    check("t7_make_count", make_count, 1);
    check("t7_key_break",  key_break,  0);
    check("t7_ovf_clear",  overflow,   0);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
